// File: rtl/ldpc_dvb_dec_cnode_restore_mx_pkg.sv
// Purpose : shared types and constants for the multi-lane check-node restore.
// Latency : n/a (types only).
// Backpres: n/a.
// Contents: default-width vnode/cnode types, the compressed per-row minimum
//           record (vn_min_t) and the normalization-mode encoding.
package ldpc_dvb_dec_cnode_restore_mx_pkg;

  localparam int NODE_W  = 8;
  localparam int CNODE_W = NODE_W;
  localparam int COL_W   = 5;

  typedef logic [NODE_W-1:0]  vnode_t;
  typedef logic [CNODE_W-1:0] cnode_t;

  // Field order fixes the bit layout of one lane word inside ivn_min:
  // min1 in the MSBs, prod_sign in bit 0.
  typedef struct packed {
    vnode_t             min1;
    vnode_t             min2;
    logic [COL_W-1:0]   min1_col;
    logic               prod_sign;
  } vn_min_t;

  typedef enum logic [1:0] {
    NORM_PLAIN     = 2'd0,
    NORM_OFFSET    = 2'd1,
    NORM_SCALE     = 2'd2,
    NORM_PLAIN_ALT = 2'd3
  } norm_mode_e;

  // Width of one packed lane word for arbitrary node/column widths.
  function automatic int vn_min_width(input int node_w, input int col_w);
    return 2 * node_w + col_w + 1;
  endfunction

endpackage

// File: rtl/ldpc_dvb_dec_cnode_norm_lane.sv
// Purpose : one lane of cnode restore: min1/min2 select + sign, then
//           normalize, saturate and convert to two's complement.
// Latency : 2 cycles (stage-1 select register, stage-2 output register).
// Backpres: none; accepts a new access every cycle.
// Ports   : imin1/imin2/imin1_col/iprod_sign - compressed row minima
//           ivnode_idx/ivnode_sign/imask     - per-access vnode info
//           inorm_mode/ioffset               - latched normalization setup
//           ocnode                           - restored signed message
module ldpc_dvb_dec_cnode_norm_lane
  import ldpc_dvb_dec_cnode_restore_mx_pkg::*;
#(
  parameter int pNODE_W  = 8,
  parameter int pCNODE_W = pNODE_W,
  parameter int pCOL_W   = 5
) (
  input  logic                iclk,
  input  logic [pNODE_W-1:0]  imin1,
  input  logic [pNODE_W-1:0]  imin2,
  input  logic [pCOL_W-1:0]   imin1_col,
  input  logic                iprod_sign,
  input  logic [pCOL_W-1:0]   ivnode_idx,
  input  logic                ivnode_sign,
  input  logic                imask,
  input  logic [1:0]          inorm_mode,
  input  logic [pNODE_W-1:0]  ioffset,
  output logic [pCNODE_W-1:0] ocnode
);

  localparam int EXT_W = (pNODE_W > pCNODE_W) ? pNODE_W : pCNODE_W;
  localparam logic [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << (pCNODE_W - 1)) - 64'd1);

  logic [pNODE_W-1:0]  abs_d, abs_q;
  logic                sign_d, sign_q;
  logic                mask_q;
  logic [pNODE_W-1:0]  norm;
  logic [EXT_W-1:0]    norm_ext;
  logic [EXT_W-1:0]    sat;
  logic [pCNODE_W-1:0] mag;
  logic [pCNODE_W-1:0] out_d, out_q;

  // Stage 1: the vnode that owns min1 must see min2 (exclude itself).
  always_comb begin
    abs_d  = (imin1_col == ivnode_idx) ? imin2 : imin1;
    sign_d = iprod_sign ^ ivnode_sign;
  end

  // Datapath registers are intentionally not reset.
  always_ff @(posedge iclk) begin
    abs_q  <= abs_d;
    sign_q <= sign_d;
    mask_q <= imask;
    out_q  <= out_d;
  end

  // Stage 2: normalize, saturate to symmetric range, apply sign.
  always_comb begin
    norm = abs_q;
    case (norm_mode_e'(inorm_mode))
      NORM_OFFSET: norm = (abs_q > ioffset) ? (abs_q - ioffset) : '0;
      NORM_SCALE:  norm = abs_q - (abs_q >> 2);
      default:     norm = abs_q;
    endcase
    norm_ext = EXT_W'(norm);
    sat      = (norm_ext > SAT_MAX) ? SAT_MAX : norm_ext;
    mag      = sat[pCNODE_W-1:0];
    // Conditional negate; saturation keeps the result away from -2^(W-1).
    out_d    = mask_q ? '0 : ((mag ^ {pCNODE_W{sign_q}}) + pCNODE_W'(sign_q));
  end

  assign ocnode = out_q;

endmodule

// File: rtl/ldpc_dvb_dec_cnode_restore_mx.sv
// Purpose : multi-lane check-node message restore with a 2-entry ping-pong
//           buffer of compressed row minima and selectable normalization.
// Latency : 2 cycles ival -> ocnode_val (ctx delayed identically).
// Backpres: none on output; oload_rdy deasserts when both entries are full,
//           loads while full are dropped and flagged in oerr[0].
// Ports   : istart/inorm_mode/ioffset - frame start and normalization setup
//           iload/ivn_min/oload_rdy   - minima write side
//           ival/irow_last/ivnode_*   - vnode access side, icnode_ctx bypass
//           ocnode_val/ocnode_ctx/ocnode - restored messages
//           oerr                      - sticky {underflow, overflow}
module ldpc_dvb_dec_cnode_restore_mx
  import ldpc_dvb_dec_cnode_restore_mx_pkg::*;
#(
  parameter int pLANE_N  = 8,
  parameter int pNODE_W  = 8,
  parameter int pCNODE_W = pNODE_W,
  parameter int pCOL_W   = 5,
  parameter int pCTX_W   = 8
) (
  input  logic                               iclk,
  input  logic                               ireset,
  input  logic                               istart,
  input  logic [1:0]                         inorm_mode,
  input  logic [pNODE_W-1:0]                 ioffset,
  input  logic                               iload,
  input  logic [pLANE_N*(2*pNODE_W+pCOL_W+1)-1:0] ivn_min,
  output logic                               oload_rdy,
  input  logic                               ival,
  input  logic                               irow_last,
  input  logic [pLANE_N*pCOL_W-1:0]          ivnode_idx,
  input  logic [pLANE_N-1:0]                 ivnode_sign,
  input  logic [pLANE_N-1:0]                 ivnode_mask,
  input  logic [pCTX_W-1:0]                  icnode_ctx,
  output logic                               ocnode_val,
  output logic [pCTX_W-1:0]                  ocnode_ctx,
  output logic [pLANE_N*pCNODE_W-1:0]        ocnode,
  output logic [1:0]                         oerr
);

  localparam int VN_W  = vn_min_width(pNODE_W, pCOL_W);
  localparam int BUF_W = pLANE_N * VN_W;

  logic [BUF_W-1:0]   buf_q [2];
  logic [1:0]         cnt_q, cnt_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         err_q, err_d;
  logic [1:0]         mode_q, mode_d;
  logic [pNODE_W-1:0] off_q, off_d;
  logic               rdy_q, rdy_d;
  logic               val1_q, val2_q;
  logic [pCTX_W-1:0]  ctx1_q, ctx2_q;

  logic               empty, full, rel, load_ok, wr_idx;
  logic [BUF_W-1:0]   rd_word;

  always_comb begin
    empty = (cnt_q == 2'd0);
    full  = (cnt_q == 2'd2);
    // istart discards the buffer state, so a coincident row end frees nothing.
    rel   = ival & irow_last & ~empty & ~istart;
    // A release in the same cycle frees the slot being written: the full
    // entry under rd_ptr is read combinationally this cycle and only
    // overwritten at the edge, so the load is safe and count stays at 2.
    load_ok = iload & (istart | ~full | rel);
    wr_idx  = istart ? 1'b0 : wr_ptr_q;

    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    mode_d   = mode_q;
    off_d    = off_q;

    if (istart) begin
      cnt_d    = load_ok ? 2'd1 : 2'd0;
      wr_ptr_d = load_ok;
      rd_ptr_d = 1'b0;
      err_d    = 2'b00;
      mode_d   = inorm_mode;
      off_d    = ioffset;
    end else begin
      cnt_d    = cnt_q + {1'b0, load_ok} - {1'b0, rel};
      wr_ptr_d = wr_ptr_q ^ load_ok;
      rd_ptr_d = rd_ptr_q ^ rel;
      err_d[0] = err_q[0] | (iload & ~load_ok);
      err_d[1] = err_q[1] | (ival & empty);
    end

    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 2'b00;
      mode_q   <= 2'd0;
      off_q    <= '0;
      rdy_q    <= 1'b1;
      val1_q   <= 1'b0;
      val2_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      off_q    <= off_d;
      rdy_q    <= rdy_d;
      val1_q   <= ival;
      val2_q   <= val1_q;
    end
  end

  // Buffer contents and bypass context are pure datapath.
  always_ff @(posedge iclk) begin
    if (load_ok) begin
      buf_q[wr_idx] <= ivn_min;
    end
    ctx1_q <= icnode_ctx;
    ctx2_q <= ctx1_q;
  end

  assign rd_word = buf_q[rd_ptr_q];

  for (genvar l = 0; l < pLANE_N; l++) begin : g_lane
    logic [VN_W-1:0] word;
    assign word = rd_word[l*VN_W +: VN_W];

    ldpc_dvb_dec_cnode_norm_lane #(
      .pNODE_W  (pNODE_W),
      .pCNODE_W (pCNODE_W),
      .pCOL_W   (pCOL_W)
    ) u_lane (
      .iclk        (iclk),
      .imin1       (word[VN_W-1 -: pNODE_W]),
      .imin2       (word[pCOL_W+pNODE_W -: pNODE_W]),
      .imin1_col   (word[pCOL_W:1]),
      .iprod_sign  (word[0]),
      .ivnode_idx  (ivnode_idx[l*pCOL_W +: pCOL_W]),
      .ivnode_sign (ivnode_sign[l]),
      // An access to an empty buffer has no valid minima: force zero.
      .imask       (ivnode_mask[l] | empty),
      .inorm_mode  (mode_q),
      .ioffset     (off_q),
      .ocnode      (ocnode[l*pCNODE_W +: pCNODE_W])
    );
  end

  assign oload_rdy  = rdy_q;
  assign ocnode_val = val2_q;
  assign ocnode_ctx = ctx2_q;
  assign oerr       = err_q;

endmodule
